// File: rtl/aes_uart_pkg.sv
// Shared types for the AES/UART byte-stream path: block geometry and
// the packer FSM state encoding.
package aes_uart_pkg;

    localparam int AES_BLK_BYTES = 16;

    typedef logic [8*AES_BLK_BYTES-1:0] aes_blk_t;
    typedef logic [AES_BLK_BYTES-1:0]   aes_keep_t;

    typedef enum logic {
        ACC = 1'b0,
        PAD = 1'b1
    } blk_pack_state_t;

endpackage

// File: rtl/taxi_axis_if.sv
// AXI-stream interface bundle with source and sink modports.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = (DATA_W > 8),
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter bit LAST_EN = 1'b1,
    parameter int ID_W    = 8,
    parameter int DEST_W  = 8,
    parameter int USER_W  = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    // Feature flags only describe which sideband fields carry meaning.
    logic unused_cfg;
    assign unused_cfg = ^{KEEP_EN, LAST_EN};

    modport src (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/aes_blk_out_reg.sv
// Single-entry output holding register: a block loads in one edge and
// is held until the downstream handshake; load and drain may coincide.
module aes_blk_out_reg
    import aes_uart_pkg::*;
#(
    parameter int DATA_W = 8 * AES_BLK_BYTES,
    parameter int KEEP_W = AES_BLK_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic              free
);

    // The slot can take a new block if empty or being drained this edge.
    assign free = !out_valid || out_ready;

    // Load takes priority over drain so back-to-back blocks leave no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_axis_blk_pack.sv
// Byte-to-block packer between the UART RX byte stream and the AES core.
// Packs BLK_BYTES bytes per block, first byte in the low lane; a frame that
// ends early yields a padded final block.
// Build option AES_BLK_PACK_PKCS7_EN selects PKCS#7 padding (full tkeep,
// pad value 16-n, extra all-pad block after a frame that ends block-aligned).
module aes_axis_blk_pack
    import aes_uart_pkg::*;
#(
    parameter int BLK_BYTES = AES_BLK_BYTES,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis,
    taxi_axis_if.src         m_axis,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy
);

    localparam int DATA_W = 8 * BLK_BYTES;
    localparam int IDX_W  = $clog2(BLK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_BYTES - 1);

    blk_pack_state_t      state, state_nxt;
    logic [IDX_W-1:0]     cnt;
    logic [DATA_W-1:0]    acc, acc_next, blk_data, ld_data, out_data;
    logic [BLK_BYTES-1:0] blk_keep, ld_keep, out_keep;
    logic                 blk_last, ld_last, out_last;
    logic                 load, accept, blk_done, out_free, out_valid, s_ready;
    logic                 unused_snk;

`ifdef AES_BLK_PACK_PKCS7_EN
    function automatic logic [7:0] pad_byte(input logic [IDX_W-1:0] c);
        return 8'(BLK_BYTES - 1 - int'(c));
    endfunction
`endif

    // tready depends combinationally on downstream tready so a draining
    // output slot can be refilled in the same edge.
    assign s_ready       = (state == ACC) && out_free;
    assign s_axis.tready = s_ready;
    assign accept        = s_axis.tvalid && s_ready;
    assign blk_done      = s_axis.tlast || (cnt == LAST_IDX);
    assign acc_next      = acc | (DATA_W'(s_axis.tdata) << (8 * cnt));
    assign busy          = (cnt != '0) || out_valid;
    assign unused_snk    = ^{s_axis.tkeep, s_axis.tstrb, s_axis.tid, s_axis.tdest, s_axis.tuser};

    // Closing block as it would leave if the current byte ends it.
    always_comb begin
        blk_data = acc_next;
        blk_keep = '0;
        blk_last = s_axis.tlast;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (i <= int'(cnt)) begin
                blk_keep[i] = 1'b1;
            end
`ifdef AES_BLK_PACK_PKCS7_EN
            else begin
                blk_data[8*i +: 8] = pad_byte(cnt);
            end
`endif
        end
`ifdef AES_BLK_PACK_PKCS7_EN
        blk_keep = '1;
        if (cnt == LAST_IDX) begin
            blk_last = 1'b0;
        end
`endif
    end

    // Next state and output-slot load selection.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ld_data   = blk_data;
        ld_keep   = blk_keep;
        ld_last   = blk_last;
        case (state)
            ACC: begin
                if (accept && blk_done) begin
                    load = 1'b1;
`ifdef AES_BLK_PACK_PKCS7_EN
                    if (s_axis.tlast && (cnt == LAST_IDX)) begin
                        state_nxt = PAD;
                    end
`endif
                end
            end
            PAD: begin
                if (out_free) begin
                    load      = 1'b1;
                    ld_data   = {BLK_BYTES{8'(BLK_BYTES)}};
                    ld_keep   = '1;
                    ld_last   = 1'b1;
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    // State register and byte accumulator; a closing byte clears the
    // accumulator because its contents have moved to the output slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACC;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (blk_done) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                    acc <= acc_next;
                end
            end
        end
    end

    // Count blocks actually delivered downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_count <= '0;
        end else if (out_valid && m_axis.tready) begin
            blk_count <= blk_count + CNT_W'(1);
        end
    end

    aes_blk_out_reg #(
        .DATA_W (DATA_W),
        .KEEP_W (BLK_BYTES)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (ld_data),
        .load_keep (ld_keep),
        .load_last (ld_last),
        .out_ready (m_axis.tready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .free      (out_free)
    );

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tstrb  = out_keep;
    assign m_axis.tlast  = out_last;
    assign m_axis.tid    = '0;
    assign m_axis.tdest  = '0;
    assign m_axis.tuser  = '0;

endmodule

// File: tb/tb_aes_axis_blk_pack.sv
// Bench for aes_axis_blk_pack: table of single-frame vectors plus directed
// sequences for backpressure, back-to-back blocks, reset and stall.
`timescale 1ns/1ps
module tb_aes_axis_blk_pack;

`ifdef AES_BLK_PACK_PKCS7_EN
    localparam bit PKCS = 1'b1;
`else
    localparam bit PKCS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] blk_count;
    logic        busy;

    taxi_axis_if #(.DATA_W(8)) s_if ();
    taxi_axis_if #(.DATA_W(128), .KEEP_EN(1'b1), .LAST_EN(1'b1)) m_if ();

    aes_axis_blk_pack #(.BLK_BYTES(16), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .blk_count (blk_count),
        .busy      (busy)
    );

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    typedef struct {
        int           nbytes;
        logic [7:0]   b0;
        logic [7:0]   step;
        int           nbeats;
        logic [127:0] d0;
        logic [15:0]  k0;
        logic         l0;
        logic [127:0] d1;
        logic [15:0]  k1;
        logic         l1;
    } vec_t;

    beat_t beats[$];
    vec_t  vecs[4];
    int    checks = 0;
    int    errors = 0;
    int    mode = 0;          // 0: tready=1, 1: toggle, 2: tready=0
    int    acc_cnt = 0;
    int    stall_cnt = 0;
    int    rule_viol = 0;
    int    exp_blk = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int w = 0;
        s_if.tdata  = b;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!s_if.tready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte 0x%0h not accepted, required within 100 cycles", b);
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (beats.size() < n && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (beats.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_beats_timeout: got %0d beats, required %0d", beats.size(), n);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("beat_count", 128'(beats.size()), 128'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Downstream tready driver, applied a little after each rising edge.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                1:       m_if.tready = ~m_if.tready;
                2:       m_if.tready = 1'b0;
                default: m_if.tready = 1'b1;
            endcase
        end
    end

    // Monitor: collects output beats, counts accepted/stalled bytes and
    // checks that a stalled output beat stays unchanged.
    initial begin
        logic  prev_stall;
        beat_t held;
        beat_t bt;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    chk("hold_tdata", m_if.tdata, held.d);
                    chk("hold_tkeep", 128'(m_if.tkeep), 128'(held.k));
                    chk("hold_tlast", 128'(m_if.tlast), 128'(held.l));
                end
                if (m_if.tvalid && m_if.tready) begin
                    bt.d = m_if.tdata;
                    bt.k = m_if.tkeep;
                    bt.l = m_if.tlast;
                    beats.push_back(bt);
                end
                if (s_if.tvalid && s_if.tready) acc_cnt++;
                if (s_if.tvalid && !s_if.tready) stall_cnt++;
                if (s_if.tready !== (!m_if.tvalid || m_if.tready)) rule_viol++;
                prev_stall = m_if.tvalid && !m_if.tready;
                held.d = m_if.tdata;
                held.k = m_if.tkeep;
                held.l = m_if.tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int           t0;
        int           cyc;
        int           acc_snap;
        logic [127:0] e;
        logic [127:0] pend_d;
        logic [15:0]  pend_k;

        vecs[0] = '{16, 8'h00, 8'h01, PKCS ? 2 : 1,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, !PKCS,
                    {16{8'h10}}, 16'hFFFF, 1'b1};
        vecs[1] = '{3, 8'hAA, 8'h11, 1,
                    PKCS ? 128'h0D0D0D0D_0D0D0D0D_0D0D0D0D_0DCCBBAA : 128'h00CCBBAA,
                    PKCS ? 16'hFFFF : 16'h0007, 1'b1, 128'h0, 16'h0, 1'b0};
        vecs[2] = '{1, 8'h5A, 8'h00, 1,
                    PKCS ? 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F5A : 128'h5A,
                    PKCS ? 16'hFFFF : 16'h0001, 1'b1, 128'h0, 16'h0, 1'b0};
        vecs[3] = '{5, 8'h10, 8'h10, 1,
                    PKCS ? 128'h0B0B0B0B_0B0B0B0B_0B0B0B50_40302010 : 128'h50_40302010,
                    PKCS ? 16'hFFFF : 16'h001F, 1'b1, 128'h0, 16'h0, 1'b0};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '0;
        s_if.tstrb  = '0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        s_if.tuser  = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("reset_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("reset_tdata", m_if.tdata, 128'(0));
        chk("reset_tkeep", 128'(m_if.tkeep), 128'(0));
        chk("reset_tlast", 128'(m_if.tlast), 128'(0));
        chk("reset_blk_count", 128'(blk_count), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_s_tready", 128'(s_if.tready), 128'(1));

        // Single frames, downstream always ready.
        for (int v = 0; v < 4; v++) begin
            beats.delete();
            for (int i = 0; i < vecs[v].nbytes; i++)
                send_byte(8'(vecs[v].b0 + vecs[v].step * i), i == vecs[v].nbytes - 1);
            chk($sformatf("vec%0d_latency_tvalid", v), 128'(m_if.tvalid), 128'(1));
            wait_beats(vecs[v].nbeats);
            exp_blk += vecs[v].nbeats;
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                if (b < beats.size()) begin
                    chk($sformatf("vec%0d_beat%0d_tdata", v, b), beats[b].d, b == 0 ? vecs[v].d0 : vecs[v].d1);
                    chk($sformatf("vec%0d_beat%0d_tkeep", v, b), 128'(beats[b].k), 128'(b == 0 ? vecs[v].k0 : vecs[v].k1));
                    chk($sformatf("vec%0d_beat%0d_tlast", v, b), 128'(beats[b].l), 128'(b == 0 ? vecs[v].l0 : vecs[v].l1));
                end
            end
            chk($sformatf("vec%0d_blk_count", v), 128'(blk_count), 128'(exp_blk));
        end

        // 48 bytes with downstream tready toggling every cycle.
        beats.delete();
        mode      = 1;
        stall_cnt = 0;
        rule_viol = 0;
        for (int i = 0; i < 48; i++) send_byte(8'(i * 7 + 3), 1'b0);
        wait_beats(3);
        mode = 0;
        for (int j = 0; j < 3; j++) begin
            e = '0;
            for (int k = 0; k < 16; k++) e[8*k +: 8] = 8'((16 * j + k) * 7 + 3);
            if (j < beats.size()) begin
                chk($sformatf("toggle_beat%0d_tdata", j), beats[j].d, e);
                chk($sformatf("toggle_beat%0d_tkeep", j), 128'(beats[j].k), 128'(16'hFFFF));
                chk($sformatf("toggle_beat%0d_tlast", j), 128'(beats[j].l), 128'(0));
            end
        end
        chk("toggle_s_tready_rule_violations", 128'(rule_viol), 128'(0));
        chk("toggle_saw_stall", 128'(stall_cnt > 0), 128'(1));
        exp_blk += 3;
        chk("toggle_blk_count", 128'(blk_count), 128'(exp_blk));

        // 32 bytes back-to-back: second block loads as the first drains.
        beats.delete();
        stall_cnt = 0;
        t0 = int'($time);
        for (int i = 0; i < 32; i++) send_byte(8'(i + 8'h40), 1'b0);
        cyc = (int'($time) - t0) / 10;
        chk("b2b_cycles_for_32_bytes", 128'(cyc), 128'(32));
        chk("b2b_stall_cycles", 128'(stall_cnt), 128'(0));
        wait_beats(2);
        for (int j = 0; j < 2; j++) begin
            e = '0;
            for (int k = 0; k < 16; k++) e[8*k +: 8] = 8'(16 * j + k + 8'h40);
            if (j < beats.size()) begin
                chk($sformatf("b2b_beat%0d_tdata", j), beats[j].d, e);
                chk($sformatf("b2b_beat%0d_tlast", j), 128'(beats[j].l), 128'(0));
            end
        end
        exp_blk += 2;
        chk("b2b_blk_count", 128'(blk_count), 128'(exp_blk));

        // Reset with an undelivered output block, then with a partial block.
        mode = 2;
        @(posedge clk);
        #1;
        beats.delete();
        for (int i = 0; i < 16; i++) send_byte(8'(i + 8'h90), 1'b0);
        chk("pend_tvalid_before_reset", 128'(m_if.tvalid), 128'(1));
        do_reset();
        mode = 0;
        chk("rst_drop_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("rst_blk_count", 128'(blk_count), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 7; i++) send_byte(8'(i + 8'hE0), 1'b0);
        chk("partial_busy", 128'(busy), 128'(1));
        do_reset();
        chk("rst2_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("rst2_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 16; i++) send_byte(8'(i + 8'h30), 1'b0);
        wait_beats(1);
        if (beats.size() > 0) begin
            chk("post_rst_tdata", beats[0].d, 128'h3F3E3D3C_3B3A3938_37363534_33323130);
            chk("post_rst_tkeep", 128'(beats[0].k), 128'(16'hFFFF));
        end
        exp_blk = 1;
        chk("post_rst_blk_count", 128'(blk_count), 128'(exp_blk));

        // Block pending with tready low: further bytes must be refused.
        pend_d = PKCS ? 128'h0C0C0C0C_0C0C0C0C_0C0C0C0C_64636261 : 128'h64636261;
        pend_k = PKCS ? 16'hFFFF : 16'h000F;
        mode = 2;
        @(posedge clk);
        #1;
        beats.delete();
        for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h61), i == 3);
        acc_snap = acc_cnt;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.tdata = 8'(8'hE8 + i);
            @(negedge clk);
            chk($sformatf("stall%0d_s_tready", i), 128'(s_if.tready), 128'(0));
            chk($sformatf("stall%0d_busy", i), 128'(busy), 128'(1));
            chk($sformatf("stall%0d_tvalid", i), 128'(m_if.tvalid), 128'(1));
            chk($sformatf("stall%0d_tdata", i), m_if.tdata, pend_d);
            chk($sformatf("stall%0d_tkeep", i), 128'(m_if.tkeep), 128'(pend_k));
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        chk("stall_no_bytes_taken", 128'(acc_cnt), 128'(acc_snap));
        mode = 0;
        wait_beats(1);
        if (beats.size() > 0) begin
            chk("stall_beat_tdata", beats[0].d, pend_d);
            chk("stall_beat_tkeep", 128'(beats[0].k), 128'(pend_k));
            chk("stall_beat_tlast", 128'(beats[0].l), 128'(1));
        end
        exp_blk += 1;
        chk("stall_blk_count", 128'(blk_count), 128'(exp_blk));
        chk("stall_no_late_bytes", 128'(acc_cnt), 128'(acc_snap));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_axis_blk_pack.md
Name: aes_axis_blk_pack

Overview:
- AXI-stream byte-to-block packer sitting between the UART RX byte stream and the AES core input.
- Sinks an 8-bit taxi_axis_if stream (snk modport) and sources a 128-bit block stream (src modport).
- Packs 16 bytes per block; a frame ending early (tlast) produces a padded final block.
- Implements the consumer end of the byte stream that the UART receiver produces.

Parameters:
- BLK_BYTES, 16, bytes per output block; m_axis DATA_W = 8*BLK_BYTES, KEEP_W = BLK_BYTES.
- CNT_W, 32, width of block counter status output.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_axis  taxi_axis_if.snk  DATA_W=8  byte input; tdata, tlast, tvalid used; tkeep/tid/tdest/tuser ignored.
- m_axis  taxi_axis_if.src  DATA_W=128, KEEP_EN=1, LAST_EN=1  block output.
- blk_count  output  CNT_W  blocks emitted on m_axis; wraps modulo 2^CNT_W.
- busy  output  1  high when byte count != 0 or m_axis.tvalid.

Behaviour:
- Reset (rst_n low at a clk edge) clears the following:
  - m_axis.tvalid = 0, tdata = 0, tkeep = 0, tlast = 0.
  - byte count = 0, accumulator = 0, blk_count = 0, state = ACC.
  - Reset mid-frame discards the partial block and any undelivered output block.
- m_axis.tid, tdest, tuser are driven 0. m_axis.tstrb equals tkeep.
- Byte order: first accepted byte goes in tdata[7:0], byte k in tdata[8k+7:8k].
- Output buffer: a single registered block.
  - s_axis.tready = state==ACC && (!m_axis.tvalid || m_axis.tready). This combinational path from m_axis.tready is intentional.
- Byte accept (s_axis.tvalid && s_axis.tready) at edge N:
  - Byte is written to acc[cnt] and cnt increments.
  - If cnt reaches 16 or tlast=1, the block transfers to the output register at the same edge. m_axis.tvalid = 1 in cycle N+1 (latency 1).
  - Output tlast = input tlast. cnt resets to 0 and the accumulator clears.
  - tkeep has bits [n-1:0] set (n = bytes in block). Unused bytes are zero.
- Simultaneous drain and load: m_axis handshake and a new block load on the same edge gives tvalid staying 1 with the new data. No bubble; sustained rate is 1 byte/cycle.
- Output handshake without a new load: tvalid drops next cycle. blk_count increments on every m_axis handshake.
- tdata/tkeep/tlast hold stable while tvalid && !tready.
- States:
  - ACC: normal accumulation.
  - PAD: used only with the optional feature. Emits an extra block, then returns to ACC.
- tlast on the 16th byte: a full block with tkeep=0xFFFF and tlast=1.
- tlast on the 1st byte: tkeep=0x0001.

Optional Feature:
- Macro AES_BLK_PACK_PKCS7_EN.
- Defined (PKCS#7 padding):
  - Final block tkeep is always 0xFFFF.
  - Padding bytes take the value 16-n.
  - If tlast arrives on a full 16-byte block, that block is emitted with tlast=0. The FSM then enters PAD (s_axis.tready=0) and loads a block of 16×0x10 with tlast=1 once the output buffer is free, then returns to ACC.
- Undefined: zero padding, partial tkeep, no PAD state.

Decomposition:
- Package aes_uart_pkg holds:
  - AES_BLK_BYTES=16.
  - Typedef aes_blk_t (logic [127:0]).
  - Typedef aes_keep_t (logic [15:0]).
  - Typedef enum blk_pack_state_t {ACC, PAD}.
- One sub-module is natural: aes_blk_out_reg, the single-entry output holding register with load/drain handshake, reusable by the matching unpacker.

Test Plan:
- Bytes 0x00..0x0F back-to-back, tlast on 0x0F, m_axis.tready=1 -> one beat at cycle 17: tdata=0x0F0E..0100, tkeep=0xFFFF, tlast=1, blk_count=1. With PKCS7_EN: tlast=0, then a second beat of all 0x10 with tlast=1, blk_count=2.
- 3 bytes 0xAA,0xBB,0xCC with tlast on 0xCC -> tdata=0x...00CCBBAA, tkeep=0x0007, tlast=1. With PKCS7_EN: tkeep=0xFFFF, bytes 3..15 = 0x0D.
- 48 bytes continuous, m_axis.tready toggling 1/0 each cycle -> s_axis.tready deasserts only while a block is held. Three correct beats, no byte lost or duplicated, data stable during stall.
- 32 bytes continuous, m_axis.tready=1 -> the second block loads on the same edge the first drains. s_axis.tready stays 1 throughout and no gap appears in acceptance.
- rst_n low for 1 cycle after 7 bytes, then 16 new bytes -> m_axis.tvalid=0 the cycle after reset. The next block contains only the new 16 bytes and blk_count restarts at 1.
- Hold m_axis.tready=0 with a block pending, drive 5 more bytes -> s_axis.tready=0, no bytes accepted, busy=1, m_axis outputs unchanged.
